// File: rtl/arb_defs.sv
// Shared definitions for the four-requester round-robin arbiter: FSM
// encodings, requester count, index width and small vector helpers.
package arb_defs;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  // Rotate right so that bit 'sh' of v lands at bit 0 of the result.
  function automatic logic [NREQ-1:0] rotr(input logic [NREQ-1:0] v,
                                           input logic [IDX_W-1:0] sh);
    logic [NREQ-1:0]  r;
    logic [IDX_W-1:0] k;
    r = '0;
    for (int i = 0; i < NREQ; i++) begin
      k    = IDX_W'(i) + sh;
      r[i] = v[k];
    end
    return r;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arb4_if import arb_defs::*;;

  logic [NREQ-1:0]  req;
  logic             done;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             nr;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, nr, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, nr, timeout
  );

endinterface

// File: rtl/prio_enc4.sv
// Fixed-priority 4-to-2 encoder, bit 0 highest; nr flags an all-zero input.
module prio_enc4 import arb_defs::*; (
  input  logic [NREQ-1:0]  d,
  output logic [IDX_W-1:0] q,
  output logic             nr
);

  always_comb begin
    q  = '0;
    nr = 1'b0;
    if (d[0])      q = 2'd0;
    else if (d[1]) q = 2'd1;
    else if (d[2]) q = 2'd2;
    else if (d[3]) q = 2'd3;
    else           nr = 1'b1;
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with grant hold timeout and a
// one-cycle flush after any forced revoke.
module rr_arb4 import arb_defs::*; #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arb4_if.slave  bus
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             nr_q, nr_d;
  logic             to_q, to_d;

  logic [IDX_W-1:0] base;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] enc;
  logic             enc_nr;
  logic [IDX_W-1:0] win;
  logic             release_c;
  logic             hold_end;

  // While busy the scan starts just past the owner and skips it, which is
  // exactly the set of candidates for a back-to-back handover.
  always_comb begin
    base = ptr_q;
    cand = bus.req;
    if (state_q == BUSY) begin
      base = idx_q + 2'd1;
      cand = bus.req & ~gnt_q;
    end
    rot = rotr(cand, base);
    win = enc + base;
  end

  prio_enc4 u_enc (
    .d  (rot),
    .q  (enc),
    .nr (enc_nr)
  );

  assign release_c = bus.done | ~|(bus.req & gnt_q);
  assign hold_end  = (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    nr_d    = nr_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!enc_nr) begin
          gnt_d   = onehot(win);
          idx_d   = win;
          nr_d    = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_c) begin
          ptr_d = idx_q + 2'd1;
          if (!enc_nr) begin
            gnt_d = onehot(win);
            idx_d = win;
            cnt_d = '0;
          end else begin
            gnt_d   = '0;
            nr_d    = 1'b1;
            state_d = IDLE;
          end
        end else if (hold_end) begin
          gnt_d   = '0;
          nr_d    = 1'b1;
          to_d    = 1'b1;
          ptr_d   = idx_q + 2'd1;
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        nr_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      nr_q    <= 1'b1;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      nr_q    <= nr_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.nr      = nr_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Randomized and directed bench for rr_arb4 against an owner/pointer
// reference model of the round-robin rules.
module tb_rr_arb4;

  localparam int MH = 8;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rr_arb4_if bus ();

  rr_arb4 #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: current owner (-1 = none), scan start, cycles
  // the owner has held the grant, last reported index, flush cycle flag.
  int m_owner, m_ptr, m_held, m_last;
  bit m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input int start, input logic [3:0] r, input int excl);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (start + k) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_last = 0; m_flush = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    if (m_flush) begin
      m_flush = 0;
    end else if (m_owner < 0) begin
      w = scan(m_ptr, r, -1);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1;
      end
    end else if (d || !r[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      w = scan(m_ptr, r, m_owner);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1;
      end else begin
        m_owner = -1;
      end
    end else if (m_held == MH) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_flush = 1;
    end else begin
      m_held++;
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk("gnt",     32'(bus.gnt),     32'(eg));
    chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_last));
    chk("nr",      32'(bus.nr),      32'(m_owner < 0));
    chk("timeout", 32'(bus.timeout), 32'(m_flush));
  endtask

  // One clock: apply inputs, advance model at the edge, compare just after.
  task automatic step(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(r, d);
    #1;
    compare_all();
  endtask

  initial begin
    bus.req  = 4'b1111;
    bus.done = 1'b0;
    rst_n    = 1'b0;
    model_reset();

    // Reset with everyone requesting
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_nr",  32'(bus.nr),  32'h1);
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    chk("rst_rel_gnt", 32'(bus.gnt), 32'h1);

    // Rotation with done pulsed on every grant
    for (int k = 1; k <= 4; k++) begin
      step(4'b1111, 1'b1);
      chk("rot_idx", 32'(bus.gnt_idx), 32'(k % 4));
      chk("rot_nr",  32'(bus.nr),      32'h0);
    end

    // Drop-release: get owner 2, then it withdraws while a and d request
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    chk("drop_own2", 32'(bus.gnt), 32'h4);
    step(4'b1001, 1'b0);
    chk("drop_next3", 32'(bus.gnt), 32'h8);
    step(4'b1001, 1'b1);
    chk("drop_wrap0", 32'(bus.gnt), 32'h1);

    // Timeout on a lone requester b
    step(4'b0000, 1'b1);
    chk("idle_nr", 32'(bus.nr), 32'h1);
    for (int k = 0; k < MH; k++) begin
      step(4'b0010, 1'b0);
      chk("to_hold", 32'(bus.gnt), 32'h2);
    end
    step(4'b0010, 1'b0);
    chk("to_pulse", 32'(bus.timeout), 32'h1);
    chk("to_nr",    32'(bus.nr),      32'h1);
    step(4'b0010, 1'b0);
    chk("to_flush_end", 32'(bus.gnt), 32'h0);
    step(4'b0010, 1'b0);
    chk("to_regrant", 32'(bus.gnt), 32'h2);

    // done on the final hold cycle is a normal release
    for (int k = 1; k < MH; k++) step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    chk("late_done_to", 32'(bus.timeout), 32'h0);
    chk("late_done_nr", 32'(bus.nr),      32'h1);

    // Asynchronous reset between edges while busy
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("async_pre", 32'(bus.gnt), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    step(4'b1111, 1'b0);
    rst_n = 1'b1;
    step(4'b1111, 1'b0);
    chk("async_restart", 32'(bus.gnt), 32'h1);

    // Randomized traffic with sticky requests and occasional done
    begin
      logic [3:0] r;
      logic       d;
      r = 4'b0000;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        d = ($urandom_range(0, 5) == 0);
        step(r, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
